// File: rtl/hero_write_arb.sv
// Round-robin transaction arbiter merging NUM_CH hero write streams onto one
// registered hero write bus, with per-channel backpressure and length limiting.
module hero_write_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 36,
    parameter int MAX_BEATS  = 8,
    parameter int CH_ID_W    = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*NUM_CH-1:0]            in_cycle_type,
    input  logic [DATA_WIDTH*NUM_CH-1:0]   in_wdat,
    input  logic [NUM_CH-1:0]              in_clk_en,
    output logic [NUM_CH-1:0]              in_ready,
    output logic [1:0]                     out_cycle_type,
    output logic [DATA_WIDTH-1:0]          out_wdat,
    output logic                           out_clk_en,
    output logic [CH_ID_W-1:0]             out_ch_id,
    input  logic                           out_ready,
    output logic                           err_overlong,
    output logic                           err_illegal,
    output logic [CH_ID_W-1:0]             err_ch
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] CT_IDLE    = 2'd0;
    localparam logic [1:0] CT_VALID   = 2'd1;
    localparam logic [1:0] CT_DONE    = 2'd2;
    localparam logic [1:0] CT_ILLEGAL = 2'd3;

    localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(MAX_BEATS - 1);
    localparam logic [CH_ID_W-1:0] LAST_CH_ID = CH_ID_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CH_ID_W-1:0]     grant_q, grant_d;
    logic [CH_ID_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [1:0]             out_ct_q, out_ct_d;
    logic [DATA_WIDTH-1:0]  out_wdat_q, out_wdat_d;
    logic                   out_clk_en_q, out_clk_en_d;
    logic [CH_ID_W-1:0]     out_ch_id_q, out_ch_id_d;
    logic                   err_overlong_q, err_overlong_d;
    logic                   err_illegal_q, err_illegal_d;
    logic [CH_ID_W-1:0]     err_ch_q, err_ch_d;

    logic [1:0]             ch_ct  [NUM_CH];
    logic [DATA_WIDTH-1:0]  ch_dat [NUM_CH];
    logic [NUM_CH-1:0]      ch_req;

    logic                   out_free;
    logic                   grant_rdy;
    logic [1:0]             g_ct;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic                   g_ce;
    logic                   g_acc;
    logic                   g_illegal;

    logic                   pick_found;
    logic [CH_ID_W-1:0]     pick_idx;

    assign out_free  = (out_ct_q == CT_IDLE) || out_ready;
    // DRAIN swallows the tail of a truncated transaction without touching the output.
    assign grant_rdy = ((state_q == ST_LOCK) && out_free) || (state_q == ST_DRAIN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_ct[gi]    = in_cycle_type[2*gi +: 2];
            assign ch_dat[gi]   = in_wdat[DATA_WIDTH*gi +: DATA_WIDTH];
            assign ch_req[gi]   = (ch_ct[gi] == CT_VALID) || (ch_ct[gi] == CT_DONE);
            assign in_ready[gi] = grant_rdy && (grant_q == CH_ID_W'(gi));
        end
    endgenerate

    assign g_ct      = ch_ct[grant_q];
    assign g_dat     = ch_dat[grant_q];
    assign g_ce      = in_clk_en[grant_q];
    assign g_acc     = grant_rdy && ((g_ct == CT_VALID) || (g_ct == CT_DONE));
    assign g_illegal = (state_q != ST_ARB) && (g_ct == CT_ILLEGAL);

    // Scan downward so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % NUM_CH;
            if (ch_req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = CH_ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        beat_cnt_d     = beat_cnt_q;
        out_ct_d       = out_ct_q;
        out_wdat_d     = out_wdat_q;
        out_clk_en_d   = out_clk_en_q;
        out_ch_id_d    = out_ch_id_q;
        err_overlong_d = 1'b0;
        err_illegal_d  = 1'b0;
        err_ch_d       = err_ch_q;

        if ((out_ct_q != CT_IDLE) && out_ready) begin
            out_ct_d = CT_IDLE;
        end

        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (g_acc) begin
                    out_ct_d     = g_ct;
                    out_wdat_d   = g_dat;
                    out_clk_en_d = g_ce;
                    out_ch_id_d  = grant_q;
                    beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                    if (g_ct == CT_DONE) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = ST_ARB;
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        out_ct_d       = CT_DONE;
                        err_overlong_d = 1'b1;
                        err_ch_d       = grant_q;
                        state_d        = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (g_acc && (g_ct == CT_DONE)) begin
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                    state_d      = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        if (g_illegal) begin
            err_illegal_d = 1'b1;
            err_ch_d      = grant_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ARB;
            grant_q        <= '0;
            last_grant_q   <= LAST_CH_ID;
            beat_cnt_q     <= '0;
            out_ct_q       <= CT_IDLE;
            out_wdat_q     <= '0;
            out_clk_en_q   <= 1'b0;
            out_ch_id_q    <= '0;
            err_overlong_q <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_ch_q       <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            beat_cnt_q     <= beat_cnt_d;
            out_ct_q       <= out_ct_d;
            out_wdat_q     <= out_wdat_d;
            out_clk_en_q   <= out_clk_en_d;
            out_ch_id_q    <= out_ch_id_d;
            err_overlong_q <= err_overlong_d;
            err_illegal_q  <= err_illegal_d;
            err_ch_q       <= err_ch_d;
        end
    end

    assign out_cycle_type = out_ct_q;
    assign out_wdat       = out_wdat_q;
    assign out_clk_en     = out_clk_en_q;
    assign out_ch_id      = out_ch_id_q;
    assign err_overlong   = err_overlong_q;
    assign err_illegal    = err_illegal_q;
    assign err_ch         = err_ch_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// Directed bench for hero_write_arb: single beat, round-robin, backpressure,
// truncation, illegal cycle type and asynchronous reset mid-transaction.
module tb_hero_write_arb;
    localparam int NUM_CH = 4;
    localparam int DW     = 36;
    localparam int IDW    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2*NUM_CH-1:0]  in_cycle_type;
    logic [DW*NUM_CH-1:0] in_wdat;
    logic [NUM_CH-1:0]    in_clk_en;
    logic [NUM_CH-1:0]    in_ready;
    logic [1:0]           out_cycle_type;
    logic [DW-1:0]        out_wdat;
    logic                 out_clk_en;
    logic [IDW-1:0]       out_ch_id;
    logic                 out_ready;
    logic                 err_overlong;
    logic                 err_illegal;
    logic [IDW-1:0]       err_ch;

    int tests = 0;
    int fails = 0;

    logic          seq_on = 1'b0;
    logic [1:0]    seq_ct  [NUM_CH][16];
    logic [DW-1:0] seq_dat [NUM_CH][16];
    int            seq_len [NUM_CH];
    int            seq_ptr [NUM_CH];

    // Expected values per cycle 1..N of each directed step.
    int rr_ct   [16] = '{0,1,1,2, 0,1,1,2, 0,1,1,2, 0,1,1,2};
    int rr_ch   [16] = '{0,0,0,0, 0,1,1,1, 1,3,3,3, 3,0,0,0};
    int rr_rdy  [16] = '{1,1,1,0, 2,2,2,0, 8,8,8,0, 1,1,1,0};
    int bp_ordy [8]  = '{1,0,0,1,1,1,1,1};
    int bp_rdy  [8]  = '{2,0,0,2,2,2,0,0};
    int bp_ct   [8]  = '{0,1,1,1,1,1,2,0};
    int bp_beat [8]  = '{-1,0,0,0,1,2,3,3};

    localparam logic [DW-1:0] BASE_A = 36'hA_0000_0000;
    localparam logic [DW-1:0] BASE_B = 36'hB_0000_0000;
    localparam logic [DW-1:0] BASE_C = 36'hC_0000_0000;
    localparam logic [DW-1:0] BASE_E = 36'hE_0000_0000;

    hero_write_arb #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_BEATS(8), .CH_ID_W(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_cycle_type(in_cycle_type), .in_wdat(in_wdat), .in_clk_en(in_clk_en),
        .in_ready(in_ready),
        .out_cycle_type(out_cycle_type), .out_wdat(out_wdat), .out_clk_en(out_clk_en),
        .out_ch_id(out_ch_id), .out_ready(out_ready),
        .err_overlong(err_overlong), .err_illegal(err_illegal), .err_ch(err_ch)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input logic [DW-1:0] base, input int k);
        return base + DW'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic seq_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            seq_len[c] = 0;
            seq_ptr[c] = 0;
        end
    endtask

    task automatic add_beat(input int c, input logic [1:0] ct, input logic [DW-1:0] d);
        seq_ct[c][seq_len[c]]  = ct;
        seq_dat[c][seq_len[c]] = d;
        seq_len[c]++;
    endtask

    task automatic drive_heads();
        for (int c = 0; c < NUM_CH; c++) begin
            if (seq_ptr[c] < seq_len[c]) begin
                in_cycle_type[2*c +: 2] = seq_ct[c][seq_ptr[c]];
                in_wdat[DW*c +: DW]     = seq_dat[c][seq_ptr[c]];
            end else begin
                in_cycle_type[2*c +: 2] = 2'd0;
            end
        end
    endtask

    task automatic set_ch(input int c, input logic [1:0] ct, input logic [DW-1:0] d);
        in_cycle_type[2*c +: 2] = ct;
        in_wdat[DW*c +: DW]     = d;
        #1;
    endtask

    // Advance one clock; sequenced channels step past beats accepted at that edge.
    task automatic tick(input logic ordy);
        logic [NUM_CH-1:0] acc;
        for (int c = 0; c < NUM_CH; c++) begin
            acc[c] = in_ready[c] && ((in_cycle_type[2*c +: 2] == 2'd1) ||
                                     (in_cycle_type[2*c +: 2] == 2'd2));
        end
        @(posedge clk);
        #1;
        if (seq_on) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) seq_ptr[c]++;
            end
            drive_heads();
        end
        out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seq_on = 1'b0;
        seq_clear();
        in_cycle_type = '0;
        in_clk_en = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic start_seq();
        seq_on = 1'b1;
        drive_heads();
        out_ready = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_cycle_type = '0;
        in_wdat = '0;
        in_clk_en = '0;
        out_ready = 1'b0;
        seq_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_ct",   64'(out_cycle_type), 64'(0));
        check("rst_out_wdat", 64'(out_wdat),       64'(0));
        check("rst_out_ce",   64'(out_clk_en),     64'(0));
        check("rst_out_ch",   64'(out_ch_id),      64'(0));
        check("rst_in_ready", 64'(in_ready),       64'(0));
        check("rst_err_ov",   64'(err_overlong),   64'(0));
        check("rst_err_il",   64'(err_illegal),    64'(0));
        check("rst_err_ch",   64'(err_ch),         64'(0));
        rst = 1'b0;
        #1;

        // Single-beat transaction on ch2
        in_clk_en[2] = 1'b1;
        out_ready = 1'b1;
        set_ch(2, 2'd2, 36'h1_2345_6789);
        check("t1_ready_c0", 64'(in_ready), 64'(0));
        tick(1'b1);
        check("t1_ready_c1", 64'(in_ready), 64'(4'b0100));
        tick(1'b1);
        set_ch(2, 2'd0, 36'h0);
        check("t1_out_ct",   64'(out_cycle_type), 64'(2));
        check("t1_out_wdat", 64'(out_wdat),       64'(36'h1_2345_6789));
        check("t1_out_ch",   64'(out_ch_id),      64'(2));
        check("t1_out_ce",   64'(out_clk_en),     64'(1));
        check("t1_ready_c2", 64'(in_ready),       64'(0));
        tick(1'b1);
        check("t1_out_ct_c3",   64'(out_cycle_type), 64'(0));
        check("t1_out_wdat_c3", 64'(out_wdat),       64'(36'h1_2345_6789));

        // Round-robin across ch0, ch1, ch3 with 3-beat transactions
        do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            if (c != 2) begin
                for (int t = 0; t < 2; t++) begin
                    add_beat(c, 2'd1, dat(BASE_A, c*16 + t*4 + 0));
                    add_beat(c, 2'd1, dat(BASE_A, c*16 + t*4 + 1));
                    add_beat(c, 2'd2, dat(BASE_A, c*16 + t*4 + 2));
                end
            end
        end
        start_seq();
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1);
            check($sformatf("rr_ct_c%0d", k),  64'(out_cycle_type), 64'(rr_ct[k-1]));
            check($sformatf("rr_ch_c%0d", k),  64'(out_ch_id),      64'(rr_ch[k-1]));
            check($sformatf("rr_rdy_c%0d", k), 64'(in_ready),       64'(rr_rdy[k-1]));
        end

        // Backpressure on a 4-beat ch1 transaction
        do_reset();
        add_beat(1, 2'd1, dat(BASE_A, 0));
        add_beat(1, 2'd1, dat(BASE_A, 1));
        add_beat(1, 2'd1, dat(BASE_A, 2));
        add_beat(1, 2'd2, dat(BASE_A, 3));
        start_seq();
        for (int k = 1; k <= 8; k++) begin
            tick(bp_ordy[k-1] != 0);
            check($sformatf("bp_rdy_c%0d", k), 64'(in_ready),       64'(bp_rdy[k-1]));
            check($sformatf("bp_ct_c%0d", k),  64'(out_cycle_type), 64'(bp_ct[k-1]));
            check($sformatf("bp_dat_c%0d", k), 64'(out_wdat),
                  64'((bp_beat[k-1] < 0) ? '0 : dat(BASE_A, bp_beat[k-1])));
        end

        // Overlong: 10 VALID + DONE on ch3, truncated at 8 beats
        do_reset();
        for (int k = 0; k < 10; k++) add_beat(3, 2'd1, dat(BASE_B, k));
        add_beat(3, 2'd2, dat(BASE_B, 10));
        start_seq();
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1);
            check($sformatf("ol_ct_c%0d", k), 64'(out_cycle_type),
                  64'((k == 1) ? 0 : (k <= 8) ? 1 : (k == 9) ? 2 : 0));
            check($sformatf("ol_rdy_c%0d", k), 64'(in_ready), 64'((k <= 11) ? 8 : 0));
            check($sformatf("ol_err_c%0d", k), 64'(err_overlong), 64'(k == 9));
            check($sformatf("ol_dat_c%0d", k), 64'(out_wdat),
                  64'((k == 1) ? '0 : (k <= 9) ? dat(BASE_B, k - 2) : dat(BASE_B, 7)));
            if (k == 9 || k == 12) begin
                check($sformatf("ol_errch_c%0d", k), 64'(err_ch), 64'(3));
            end
        end

        // Illegal cycle type and idle stall on ch0 (ch0 next after ch3)
        seq_on = 1'b0;
        tick(1'b1);
        set_ch(0, 2'd1, dat(BASE_C, 0));
        check("il_rdy_c0", 64'(in_ready), 64'(0));
        tick(1'b1);
        check("il_rdy_c1", 64'(in_ready), 64'(1));
        tick(1'b1);
        set_ch(0, 2'd3, dat(BASE_C, 9));
        check("il_ct_c2",    64'(out_cycle_type), 64'(1));
        check("il_dat_c2",   64'(out_wdat),       64'(dat(BASE_C, 0)));
        check("il_rdy_c2",   64'(in_ready),       64'(1));
        check("il_err_c2",   64'(err_illegal),    64'(0));
        check("il_errch_c2", 64'(err_ch),         64'(3));
        tick(1'b1);
        set_ch(0, 2'd0, dat(BASE_C, 9));
        check("il_err_c3",   64'(err_illegal),    64'(1));
        check("il_errch_c3", 64'(err_ch),         64'(0));
        check("il_ct_c3",    64'(out_cycle_type), 64'(0));
        for (int k = 4; k <= 7; k++) begin
            tick(1'b1);
            check($sformatf("il_err_c%0d", k), 64'(err_illegal), 64'(0));
            check($sformatf("il_rdy_c%0d", k), 64'(in_ready),    64'(1));
        end
        tick(1'b1);
        set_ch(0, 2'd2, dat(BASE_C, 1));
        check("il_rdy_c8", 64'(in_ready), 64'(1));
        tick(1'b1);
        set_ch(0, 2'd0, dat(BASE_C, 1));
        check("il_ct_c9",  64'(out_cycle_type), 64'(2));
        check("il_dat_c9", 64'(out_wdat),       64'(dat(BASE_C, 1)));
        check("il_ch_c9",  64'(out_ch_id),      64'(0));
        check("il_rdy_c9", 64'(in_ready),       64'(0));

        // Asynchronous reset after the 2nd beat of a 5-beat ch2 transaction
        seq_clear();
        for (int k = 0; k < 4; k++) add_beat(2, 2'd1, dat(BASE_E, k));
        add_beat(2, 2'd2, dat(BASE_E, 4));
        seq_on = 1'b1;
        tick(1'b1);
        check("rs_rdy_c0", 64'(in_ready), 64'(0));
        tick(1'b1);
        check("rs_rdy_c1", 64'(in_ready), 64'(4'b0100));
        tick(1'b1);
        tick(1'b1);
        check("rs_dat_c3", 64'(out_wdat),       64'(dat(BASE_E, 1)));
        check("rs_ct_c3",  64'(out_cycle_type), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_ct",   64'(out_cycle_type), 64'(0));
        check("rs_async_rdy",  64'(in_ready),       64'(0));
        check("rs_async_ov",   64'(err_overlong),   64'(0));
        check("rs_async_il",   64'(err_illegal),    64'(0));
        check("rs_async_wdat", 64'(out_wdat),       64'(0));
        seq_on = 1'b0;
        seq_clear();
        in_cycle_type = '0;
        in_wdat[2*DW +: DW] = '0;
        set_ch(0, 2'd2, dat(BASE_E, 16));
        set_ch(3, 2'd2, dat(BASE_E, 48));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rs_rdy_rel_c0", 64'(in_ready), 64'(0));
        tick(1'b1);
        check("rs_rdy_rel_c1", 64'(in_ready), 64'(1));
        tick(1'b1);
        check("rs_ct_rel_c2",  64'(out_cycle_type), 64'(2));
        check("rs_ch_rel_c2",  64'(out_ch_id),      64'(0));
        check("rs_dat_rel_c2", 64'(out_wdat),       64'(dat(BASE_E, 16)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hero_write_arb.md
Name: hero_write_arb

Overview:
- N-channel arbiter for the hero write bus: merges NUM_CH upstream hero write streams onto one downstream hero write bus.
- Grants at transaction granularity, round-robin. A transaction is zero or more VALID beats closed by one DONE beat.
- Adds per-channel backpressure, a registered output with channel tag, and enforcement of a maximum transaction length.
- Sits between multiple hero write masters and a single hero write consumer.

Parameters:
- NUM_CH, 4, number of upstream channels (2..16).
- DATA_WIDTH, 36, wdat width per beat.
- MAX_BEATS, 8, maximum beats per transaction including DONE (2..256).
- CH_ID_W, $clog2(NUM_CH), width of the channel tag.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_cycle_type  in  2*NUM_CH  per-channel cycle type: IDLE=0, VALID=1, DONE=2; 3 is illegal
- in_wdat  in  DATA_WIDTH*NUM_CH  per-channel write data
- in_clk_en  in  NUM_CH  per-channel clock-enable field
- in_ready  out  NUM_CH  per-channel beat accept
- out_cycle_type  out  2  merged cycle type
- out_wdat  out  DATA_WIDTH  merged data
- out_clk_en  out  1  merged clk_en field
- out_ch_id  out  CH_ID_W  source channel of the current out beat
- out_ready  in  1  downstream accept
- err_overlong  out  1  one-cycle pulse: transaction truncated at MAX_BEATS
- err_illegal  out  1  one-cycle pulse: cycle type 3 seen on the granted channel
- err_ch  out  CH_ID_W  channel associated with the last error pulse; holds its value

Behaviour:
- Handshakes:
  - Input beat on channel g is accepted when in_cycle_type[g]!=IDLE && in_ready[g] at a rising edge.
  - Output is valid when out_cycle_type!=IDLE; it is consumed when out_ready=1 at an edge.
- Output register:
  - Single stage; out_* change only on a load or a consume.
  - Load enable = accepted beat in LOCK state. out_free = (out_cycle_type==IDLE) || out_ready.
  - Consume with no load: out_cycle_type->IDLE, other out_* hold.
- State ARB (reset state):
  - in_ready all 0.
  - Requesters are channels with cycle type VALID or DONE.
  - Pick the first requester searching from last_grant+1 with wrap modulo NUM_CH, register it as grant, go to LOCK.
  - With no requester, stay in ARB.
  - This costs one bubble cycle per transaction.
- State LOCK:
  - in_ready[grant] = out_free; every other in_ready is 0.
  - On an accepted beat: out_cycle_type/out_wdat/out_clk_en take the granted inputs, out_ch_id=grant, beat_cnt++.
  - Accepted DONE: last_grant=grant, beat_cnt=0, go to ARB.
  - Accepted VALID with beat_cnt==MAX_BEATS-1: the beat is output as DONE, err_overlong pulses, err_ch=grant, go to DRAIN.
  - IDLE on the granted channel mid-transaction: stall, hold the grant indefinitely, no error.
  - Cycle type 3 on the granted channel: treated as IDLE (not accepted, in_ready still driven), err_illegal pulses every such cycle, err_ch=grant.
- State DRAIN:
  - in_ready[grant]=1 regardless of out_free; accepted beats are discarded (no output load).
  - Accepted DONE: last_grant=grant, beat_cnt=0, go to ARB.
- beat_cnt: width $clog2(MAX_BEATS+1); never wraps because LOCK exits at MAX_BEATS.
- Latency:
  - Request first visible in cycle 0; grant registered at the end of cycle 0; in_ready high in cycle 1.
  - Beat accepted end of cycle 1, appears on out_* in cycle 2.
  - Steady state in LOCK is 1 beat/cycle while out_ready=1.
- Simultaneous load and consume in the same cycle: the new beat replaces the old one; no bubble.
- Reset values:
  - out_cycle_type=IDLE, out_wdat=0, out_clk_en=0, out_ch_id=0.
  - in_ready=0, err_overlong=0, err_illegal=0, err_ch=0.
  - state=ARB, beat_cnt=0, last_grant=NUM_CH-1, so channel 0 has priority first.
- Reset mid-transaction: all state clears immediately (asynchronous). The partial transaction is lost downstream with no DONE. Upstream must also be reset.

Test Plan:
- Single-beat transaction:
  - Stimulus: ch2 drives DONE, wdat=0x123456789, out_ready=1.
  - Response: in_ready[2]=1 in cycle 1; out cycle 2 = DONE, wdat 0x123456789, ch_id=2; state back to ARB.
- Round-robin at transaction boundaries:
  - Stimulus: ch0, ch1 and ch3 all request 3-beat transactions (V,V,D) continuously, out_ready=1.
  - Response: out_ch_id sequence is 0,0,0,1,1,1,3,3,3,0…; each group ends in DONE; one bubble between groups; no interleave.
- Backpressure:
  - Stimulus: ch1 runs a 4-beat transaction while out_ready toggles 1,0,0,1,1…
  - Response: in_ready[1] low while the output register is full and out_ready=0; all 4 beats appear in order, none dropped or duplicated.
- Overlong transaction:
  - Stimulus: MAX_BEATS=8, ch3 sends 10 VALID then DONE.
  - Response: output shows 7 VALID then 1 DONE (the 8th beat); err_overlong pulses once with err_ch=3; the remaining 2 VALID+DONE are drained with in_ready[3]=1 and no output; then ARB.
- Illegal cycle type and mid-transaction idle:
  - Stimulus: granted ch0 drives V, then 3, then IDLE x5, then D.
  - Response: err_illegal pulses for 1 cycle with err_ch=0; grant held through the idle cycles; output is V then D.
- Reset mid-transaction:
  - Stimulus: assert rst asynchronously after the 2nd beat of a 5-beat transaction.
  - Response: in the same cycle out_cycle_type=IDLE, in_ready=0, errors=0; after release, ch0 gets priority first.
